// File: rtl/if_fetch_ctrl.sv
// if_fetch_ctrl: single-outstanding instruction fetch sequencer with redirect and stale-response discard
module if_fetch_ctrl #(
  parameter logic [63:0] PC_START = 64'h0000_0000_8000_0000,
  parameter int INST_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect_valid,
  input  logic [63:0]       redirect_pc,
  input  logic              stall,
  output logic              imem_req_valid,
  output logic [63:0]       imem_req_addr,
  input  logic              imem_req_ready,
  input  logic              imem_resp_valid,
  input  logic [INST_W-1:0] imem_resp_data,
  input  logic              imem_resp_err,
  output logic              inst_valid,
  output logic [63:0]       inst_pc,
  output logic [INST_W-1:0] inst,
  output logic              fetch_err
);
  typedef enum logic [2:0] {IDLE, REQ, WAIT, DROP, OUT} state_t;
  state_t state_q, state_d;
  logic [63:0] pc_q, pc_d, inst_pc_q, inst_pc_d, tgt;
  logic [INST_W-1:0] inst_q, inst_d;
  logic err_q, err_d;
  assign tgt = redirect_pc & ~64'd3;
  assign imem_req_addr = pc_q;
  assign imem_req_valid = (state_q == REQ) && !redirect_valid;
  assign inst_valid = (state_q == OUT) && !redirect_valid;
  assign inst_pc = inst_pc_q;
  assign inst = inst_q;
  assign fetch_err = err_q;
  // next-state: redirect overrides stall and any same-cycle response; DROP waits out the stale response
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    inst_d = inst_q;
    inst_pc_d = inst_pc_q;
    err_d = err_q;
    case (state_q)
      IDLE: state_d = REQ;
      REQ:
        if (redirect_valid) pc_d = tgt;
        else if (imem_req_ready) state_d = WAIT;
      WAIT:
        if (imem_resp_valid && redirect_valid) begin
          pc_d = tgt;
          state_d = REQ;
        end else if (imem_resp_valid) begin
          inst_d = imem_resp_data;
          inst_pc_d = pc_q;
          err_d = imem_resp_err;
          pc_d = pc_q + 64'd4;
          state_d = OUT;
        end else if (redirect_valid) begin
          pc_d = tgt;
          state_d = DROP;
        end
      DROP: begin
        pc_d = redirect_valid ? tgt : pc_q;
        state_d = imem_resp_valid ? REQ : DROP;
      end
      OUT:
        if (redirect_valid) begin
          pc_d = tgt;
          state_d = REQ;
        end else if (!stall) state_d = REQ;
      default: state_d = IDLE;
    endcase
  end
  // state and presented-instruction registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q <= PC_START;
      inst_q <= '0;
      inst_pc_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      inst_q <= inst_d;
      inst_pc_q <= inst_pc_d;
      err_q <= err_d;
    end
  end
endmodule
